// File: rtl/freq_digit_scanner.sv
// Frequency index register, index-to-digit-code decode and N-digit common-anode scan.
// Optional CHANGE_FLASH_EN macro: blank all anodes for 2*N_DIGITS slot advances after an index change.
module freq_digit_scanner #(
   parameter int N_DIGITS    = 4,
   parameter int IDX_W       = 3,
   parameter int MAX_IDX     = 7,
   parameter int REFRESH_DIV = 50000,
   parameter int WRAP        = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_up,
   input  logic                btn_down,
   input  logic                idx_load,
   input  logic [IDX_W-1:0]    idx_in,
   output logic [IDX_W-1:0]    indicador,
   output logic [3:0]          digit_code,
   output logic [N_DIGITS-1:0] anode,
   output logic                frame_done
);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int SEL_W = $clog2(N_DIGITS);
   localparam logic [IDX_W-1:0]    MAX_V       = IDX_W'(MAX_IDX);
   localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
   localparam logic [SEL_W-1:0]    SEL_LAST    = SEL_W'(N_DIGITS - 1);
   localparam logic [15:0]         ROW_RESET   = 16'h0A39;
   localparam logic [N_DIGITS-1:0] ANODE_RESET = ~(N_DIGITS'(1));

   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [15:0]         dig_q, dig_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [N_DIGITS-1:0] anode_q, anode_d, onehot_d;
   logic [3:0]          code_q, code_d;
   logic                frame_q, frame_d;
   logic                slot_tc;
   logic [3:0]          code_slot [N_DIGITS];

   // Index update: load wins, a lone up or down steps, both together cancel.
   always_comb begin
      idx_d = idx_q;
      if (idx_load) begin
         idx_d = (idx_in > MAX_V) ? MAX_V : idx_in;
      end else if (btn_up && !btn_down) begin
         if (idx_q >= MAX_V)
            idx_d = (WRAP != 0) ? '0 : MAX_V;
         else
            idx_d = idx_q + 1'b1;
      end else if (btn_down && !btn_up) begin
         if (idx_q == '0)
            idx_d = (WRAP != 0) ? MAX_V : '0;
         else
            idx_d = idx_q - 1'b1;
      end
   end

   // Row packing is {d3,d2,d1,d0}, 4 bits each; d0 is the rightmost digit.
   always_comb begin
      case (int'(idx_q))
         1:       dig_d = 16'h0A78;
         2:       dig_d = 16'h1A56;
         3:       dig_d = 16'h3A12;
         4:       dig_d = 16'h6A25;
         5:       dig_d = 16'h12A5;
         6:       dig_d = 16'h25A0;
         7:       dig_d = 16'h50A0;
         default: dig_d = ROW_RESET;
      endcase
   end

   assign slot_tc = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d   = slot_tc ? '0 : cnt_q + 1'b1;
      sel_d   = sel_q;
      frame_d = 1'b0;
      if (slot_tc) begin
         sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
         frame_d = (sel_q == SEL_LAST);
      end
   end

   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_slot
         if (gi < 4) begin : g_dig
            assign code_slot[gi] = dig_q[gi*4 +: 4];
         end else begin : g_blank
            assign code_slot[gi] = 4'hF;
         end
         assign onehot_d[gi] = (sel_d != SEL_W'(gi));
      end
   endgenerate

   assign code_d = code_slot[sel_d];

`ifdef CHANGE_FLASH_EN
   localparam int BLK_W = $clog2(2*N_DIGITS + 1);
   localparam logic [BLK_W-1:0] BLK_FULL = BLK_W'(2*N_DIGITS);
   logic [BLK_W-1:0] blank_q, blank_d;

   // A change restarts the window even when it coincides with a slot advance.
   always_comb begin
      blank_d = blank_q;
      if (idx_d != idx_q)
         blank_d = BLK_FULL;
      else if (slot_tc && (blank_q != '0))
         blank_d = blank_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         blank_q <= '0;
      else
         blank_q <= blank_d;
   end

   assign anode_d = (blank_d != '0) ? '1 : onehot_d;
`else
   assign anode_d = onehot_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         dig_q   <= ROW_RESET;
         cnt_q   <= '0;
         sel_q   <= '0;
         anode_q <= ANODE_RESET;
         code_q  <= ROW_RESET[3:0];
         frame_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         anode_q <= anode_d;
         code_q  <= code_d;
         frame_q <= frame_d;
      end
   end

   assign indicador  = idx_q;
   assign digit_code = code_q;
   assign anode      = anode_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_freq_digit_scanner.sv
// Directed bench for freq_digit_scanner: saturating instance (MAX 7) and wrapping instance (MAX 5).
module tb_freq_digit_scanner;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, idx_load = 1'b0;
   logic [2:0] idx_in = 3'd0;
   logic [2:0] ind_a, ind_b;
   logic [3:0] code_a, code_b, an_a, an_b;
   logic       fd_a, fd_b;

   int checks = 0;
   int failures = 0;
   int cyc;
   logic [2:0] exp_a_q [$];
   logic [2:0] exp_b_q [$];
   logic [3:0] exp_code_q [$];

   always #5 clk = ~clk;

   freq_digit_scanner #(.N_DIGITS(4), .IDX_W(3), .MAX_IDX(7), .REFRESH_DIV(4), .WRAP(0)) dut_a (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .idx_load(idx_load),
      .idx_in(idx_in), .indicador(ind_a), .digit_code(code_a), .anode(an_a), .frame_done(fd_a));

   freq_digit_scanner #(.N_DIGITS(4), .IDX_W(3), .MAX_IDX(5), .REFRESH_DIV(4), .WRAP(1)) dut_b (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .idx_load(idx_load),
      .idx_in(idx_in), .indicador(ind_b), .digit_code(code_b), .anode(an_b), .frame_done(fd_b));

   // Clock edges since reset release.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] exp_anode(int k);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << ((k / 4) % 4));
   endfunction

   task automatic run_scan(int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk("anode", an_a, exp_anode(cyc));
         chk("frame_done", fd_a, (cyc % 16 == 0));
         if ((cyc % 4 == 0) && (exp_code_q.size() > 0))
            chk("digit_code", code_a, exp_code_q.pop_front());
      end
   endtask

   task automatic wait_mod(string tag, int m, int r);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (cyc % m == r) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk(tag, found, 1);
   endtask

   // Must be called at a frame start (digit_sel just became 0).
   task automatic scan_frame(logic [3:0] d0, logic [3:0] d1, logic [3:0] d2, logic [3:0] d3);
      exp_code_q.push_back(d0);
      exp_code_q.push_back(d1);
      exp_code_q.push_back(d2);
      exp_code_q.push_back(d3);
      chk("frame_start", fd_a, 1);
      chk("digit_code", code_a, exp_code_q.pop_front());
      run_scan(12);
   endtask

   task automatic pulse(string tag, logic up, logic dn, logic ld, logic [2:0] v,
                        logic [2:0] ea, logic [2:0] eb);
      btn_up = up; btn_down = dn; idx_load = ld; idx_in = v;
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
      step();
      btn_up = 1'b0; btn_down = 1'b0; idx_load = 1'b0; idx_in = 3'd0;
      chk({tag, "_a"}, ind_a, exp_a_q.pop_front());
      chk({tag, "_b"}, ind_b, exp_b_q.pop_front());
`ifndef CHANGE_FLASH_EN
      chk({tag, "_anode"}, an_a, exp_anode(cyc));
`endif
   endtask

   task automatic settle();
      step();
      step();
`ifdef CHANGE_FLASH_EN
      repeat (40) step();
`endif
   endtask

   initial begin
      repeat (3) step();
      chk("rst_indicador", ind_a, 0);
      chk("rst_anode", an_a, 4'b1110);
      chk("rst_frame_done", fd_a, 0);
      chk("rst_indicador_b", ind_b, 0);
      reset = 1'b0;
      chk("rel_anode", an_a, exp_anode(cyc));

      // First frame after release: digit codes 9,3,10,0.
      exp_code_q.push_back(4'd3);
      exp_code_q.push_back(4'd10);
      exp_code_q.push_back(4'd0);
      run_scan(12);
      wait_mod("sync0", 16, 0);
      scan_frame(4'd9, 4'd3, 4'd10, 4'd0);

      pulse("up1", 1, 0, 0, 3'd0, 3'd1, 3'd1);
      pulse("up2", 1, 0, 0, 3'd0, 3'd2, 3'd2);
      pulse("up3", 1, 0, 0, 3'd0, 3'd3, 3'd3);
      settle();
      wait_mod("sync3", 16, 0);
      scan_frame(4'd2, 4'd1, 4'd10, 4'd3);

      pulse("load7", 0, 0, 1, 3'd7, 3'd7, 3'd5);
      settle();
      wait_mod("sync7", 16, 0);
      scan_frame(4'd0, 4'd10, 4'd0, 4'd5);

      pulse("up_limit", 1, 0, 0, 3'd0, 3'd7, 3'd0);
      pulse("down_b_wrap", 0, 1, 0, 3'd0, 3'd6, 3'd5);
      pulse("up_and_down", 1, 1, 0, 3'd0, 3'd6, 3'd5);
      pulse("load6_clamp", 0, 0, 1, 3'd6, 3'd6, 3'd5);
      pulse("load0", 0, 0, 1, 3'd0, 3'd0, 3'd0);
      pulse("down_limit", 0, 1, 0, 3'd0, 3'd0, 3'd5);
      pulse("both_at_limit", 1, 1, 0, 3'd0, 3'd0, 3'd5);
      pulse("load_over_up", 1, 0, 1, 3'd2, 3'd2, 3'd2);
      settle();
      wait_mod("sync2", 16, 0);
      scan_frame(4'd6, 4'd5, 4'd10, 4'd1);

`ifdef CHANGE_FLASH_EN
      wait_mod("align1", 4, 3);
      pulse("flash_up", 1, 0, 0, 3'd0, 3'd3, 3'd3);
      chk("flash_start", an_a, 4'hF);
      repeat (31) begin
         step();
         chk("flash_blank", an_a, 4'hF);
      end
      step();
      chk("flash_end", an_a, exp_anode(cyc));

      wait_mod("align2", 4, 3);
      pulse("flash_up2", 1, 0, 0, 3'd0, 3'd4, 3'd4);
      repeat (19) begin
         step();
         chk("flash_blank2", an_a, 4'hF);
      end
      pulse("flash_restart", 1, 0, 0, 3'd0, 3'd5, 3'd5);
      chk("flash_restart_blank", an_a, 4'hF);
      repeat (31) begin
         step();
         chk("flash_blank3", an_a, 4'hF);
      end
      step();
      chk("flash_end2", an_a, exp_anode(cyc));
`endif

      // Asynchronous reset while digit 2 is lit.
      wait_mod("sync_sel2", 16, 8);
      chk("pre_rst_anode", an_a, 4'b1011);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_anode", an_a, 4'b1110);
      chk("async_rst_indicador", ind_a, 0);
      chk("async_rst_indicador_b", ind_b, 0);
      chk("async_rst_frame_done", fd_a, 0);
      step();
      step();
      reset = 1'b0;
      exp_code_q.push_back(4'd3);
      exp_code_q.push_back(4'd10);
      exp_code_q.push_back(4'd0);
      run_scan(12);
      wait_mod("sync_post", 16, 0);
      scan_frame(4'd9, 4'd3, 4'd10, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
